regfile: RTL and testbench



---
 rtl/regfile_if.sv | 21 ++
 rtl/regfile.sv | 55 +++++
 tb/tb_regfile.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_if.sv
// Operand/write bundle between decode and the architectural register file.
// Master drives indices and write data; slave returns the two operands.
interface regfile_if;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;

  modport master (
    output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    input  ReadData1, ReadData2
  );

  modport slave (
    input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    output ReadData1, ReadData2
  );
endinterface

// File: rtl/regfile.sv
// 32 x 64-bit register file: one clocked write port, two combinational read ports.
// Index 31 is XZR: writes are dropped and reads return zero.
module regfile (
  input  logic     clk,
  input  logic     reset,
  regfile_if.slave rf
);

  logic [63:0] regs_q   [31];
  logic [63:0] regs_d   [31];
  logic [30:0] wr_en;
  logic [63:0] lo_bank  [16];
  logic [63:0] hi_bank  [16];
  logic [63:0] rd1_lo, rd1_hi, rd2_lo, rd2_hi;

  // One-hot write decode; index 31 has no enable line at all.
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < 31; i++) begin
      wr_en[i] = rf.RegWrite && (rf.WriteRegister == 5'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < 31; i++) begin
      regs_d[i] = wr_en[i] ? rf.WriteData : regs_q[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 31; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < 31; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Mux cell inputs; slot 15 of the high cell is the hardwired zero.
  always_comb begin
    for (int i = 0; i < 16; i++) lo_bank[i] = regs_q[i];
    for (int i = 0; i < 15; i++) hi_bank[i] = regs_q[16 + i];
    hi_bank[15] = '0;
  end

  always_comb begin
    rd1_lo = lo_bank[rf.ReadRegister1[3:0]];
    rd1_hi = hi_bank[rf.ReadRegister1[3:0]];
    rd2_lo = lo_bank[rf.ReadRegister2[3:0]];
    rd2_hi = hi_bank[rf.ReadRegister2[3:0]];
  end

  assign rf.ReadData1 = rf.ReadRegister1[4] ? rd1_hi : rd1_lo;
  assign rf.ReadData2 = rf.ReadRegister2[4] ? rd2_hi : rd2_lo;

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: reference array model, expected-value queue,
// a vector table and directed sequences for reset, disable and no-bypass cases.
module tb_regfile;

  localparam logic [63:0] BASE = 64'h0123_4567_89AB_0000;

  logic clk = 1'b0;
  logic reset;
  regfile_if rf_bus();

  regfile dut (.clk(clk), .reset(reset), .rf(rf_bus));

  always #5 clk = ~clk;

  logic [63:0] model [32];
  logic [63:0] exp_q [$];
  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        we;
    logic [4:0]  wr;
    logic [63:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [63:0] e1;
    logic [63:0] e2;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  // Drive a write at negedge, let one rising edge pass, update the model.
  task automatic wr_cycle(input logic we, input logic [4:0] idx, input logic [63:0] d);
    @(negedge clk);
    rf_bus.RegWrite      = we;
    rf_bus.WriteRegister = idx;
    rf_bus.WriteData     = d;
    @(posedge clk);
    #1;
    if (we && idx != 5'd31) model[idx] = d;
    rf_bus.RegWrite = 1'b0;
  endtask

  // Drive read indices, push model expectations, then pop and compare.
  task automatic rd_chk(input string name, input logic [4:0] r1, input logic [4:0] r2);
    logic [63:0] e1, e2;
    rf_bus.ReadRegister1 = r1;
    rf_bus.ReadRegister2 = r2;
    exp_q.push_back(model[r1]);
    exp_q.push_back(model[r2]);
    #1;
    e1 = exp_q.pop_front();
    e2 = exp_q.pop_front();
    chk({name, "_p1"}, rf_bus.ReadData1, e1);
    chk({name, "_p2"}, rf_bus.ReadData2, e2);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31, 64'h0, 64'h0};
    vecs[1] = '{1'b0, 5'd5,  64'hDEAD_BEEF_DEAD_BEEF, 5'd5,  5'd5,  BASE + 64'd5, BASE + 64'd5};
    vecs[2] = '{1'b1, 5'd7,  64'h11,                  5'd7,  5'd8,  64'h11, BASE + 64'd8};
    vecs[3] = '{1'b1, 5'd0,  64'hA5A5_A5A5_A5A5_A5A5, 5'd0,  5'd30, 64'hA5A5_A5A5_A5A5_A5A5, BASE + 64'd30};
    vecs[4] = '{1'b0, 5'd0,  64'h0,                   5'd0,  5'd31, 64'hA5A5_A5A5_A5A5_A5A5, 64'h0};
    vecs[5] = '{1'b1, 5'd30, 64'h8000_0000_0000_0001, 5'd30, 5'd16, 64'h8000_0000_0000_0001, BASE + 64'd16};
    vecs[6] = '{1'b1, 5'd16, 64'h1,                   5'd16, 5'd15, 64'h1, BASE + 64'd15};

    rf_bus.RegWrite      = 1'b0;
    rf_bus.WriteRegister = '0;
    rf_bus.WriteData     = '0;
    rf_bus.ReadRegister1 = '0;
    rf_bus.ReadRegister2 = '0;
    model_clear();

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rd_chk("rst0_31", 5'd0, 5'd31);
    rd_chk("rst15_16", 5'd15, 5'd16);
    rd_chk("rst30", 5'd30, 5'd30);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 31; i++) wr_cycle(1'b1, 5'(i), BASE + 64'(i));
    for (int i = 0; i < 31; i++) rd_chk($sformatf("sweep%0d", i), 5'(i), 5'(30 - i));

    foreach (vecs[k]) begin
      wr_cycle(vecs[k].we, vecs[k].wr, vecs[k].wd);
      rf_bus.ReadRegister1 = vecs[k].r1;
      rf_bus.ReadRegister2 = vecs[k].r2;
      exp_q.push_back(vecs[k].e1);
      exp_q.push_back(vecs[k].e2);
      #1;
      chk($sformatf("vec%0d_p1", k), rf_bus.ReadData1, exp_q.pop_front());
      chk($sformatf("vec%0d_p2", k), rf_bus.ReadData2, exp_q.pop_front());
      if (k == 0)
        for (int i = 0; i < 31; i++) rd_chk($sformatf("xzr_keep%0d", i), 5'(i), 5'd31);
    end

    // Disabled writes across three edges, with data wiggling between edges.
    @(negedge clk);
    rf_bus.RegWrite      = 1'b0;
    rf_bus.WriteRegister = 5'd5;
    rf_bus.WriteData     = 64'hDEAD_BEEF_DEAD_BEEF;
    repeat (3) begin
      @(posedge clk);
      #2;
      rf_bus.WriteData = ~rf_bus.WriteData;
    end
    rd_chk("wdis5", 5'd5, 5'd4);

    // No bypass: old value until the edge, new value after it.
    @(negedge clk);
    rf_bus.ReadRegister1 = 5'd7;
    rf_bus.ReadRegister2 = 5'd7;
    rf_bus.RegWrite      = 1'b1;
    rf_bus.WriteRegister = 5'd7;
    rf_bus.WriteData     = 64'h99;
    #1;
    rf_bus.WriteData     = 64'h22;
    #1;
    chk("nobyp_before", rf_bus.ReadData1, 64'h11);
    @(posedge clk);
    #1;
    rf_bus.RegWrite = 1'b0;
    model[7] = 64'h22;
    chk("nobyp_after", rf_bus.ReadData1, 64'h22);
    rd_chk("nobyp_model", 5'd7, 5'd6);

    // Asynchronous reset pulse with no clock edge inside it.
    @(negedge clk);
    #1;
    reset = 1'b1;
    model_clear();
    #1;
    rd_chk("arst0_15", 5'd0, 5'd15);
    rd_chk("arst16_30", 5'd16, 5'd30);
    #1;
    reset = 1'b0;
    rd_chk("arst_rel", 5'd7, 5'd30);

    // Reset held across an edge that carries a write: the write is lost.
    wr_cycle(1'b1, 5'd3, 64'h1234);
    @(negedge clk);
    reset                = 1'b1;
    rf_bus.RegWrite      = 1'b1;
    rf_bus.WriteRegister = 5'd3;
    rf_bus.WriteData     = 64'h55;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rf_bus.RegWrite = 1'b0;
    reset = 1'b0;
    rd_chk("rstwr3", 5'd3, 5'd3);

    // First edge after release writes normally.
    wr_cycle(1'b1, 5'd3, 64'h66);
    rd_chk("postrst3", 5'd3, 5'd31);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
